jpeg_idct_transpose_mb: RTL

Parametrised multi-buffer transpose stage between the IDCT row pass and the column pass. It accepts one coefficient per cycle, addressed by block index 0..63, into one of NUM_BUFS block buffers. Completed blocks are emitted LANES samples per beat, either column-major (transpose) or raster (bypass), over a full valid/ready handshake that tolerates back-pressure. It generalises the fixed 2-buffer, 4-lane transpose with configurable width, lane count and depth, a per-block mode, partial-block discard and an output stall.

---
 rtl/jpeg_idct_transpose_mb.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/jpeg_idct_transpose_mb.sv
// jpeg_idct_transpose_mb
// Multi-buffer transpose stage between the IDCT row pass and column pass.
// Coefficients arrive one per cycle, addressed by raster index 0..63, into
// one of NUM_BUFS block buffers. Completed blocks leave LANES samples per
// beat, column-major (transpose) or raster (bypass), chosen per block.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-low reset
//   img_start_i           synchronous clear of all buffer state (top priority)
//   img_end_i             discard the partially written block
//   mode_transpose_i      1 = column-major output, 0 = raster bypass
//   inport_*              sample write: valid/data/idx, accept
//   outport_*             beat output: valid/data/idx/last, ready
//   buf_level_o           complete blocks held, including the one being read
//   idle_o                nothing held, nothing partial, output invalid
module jpeg_idct_transpose_mb #(
  parameter int DATA_W   = 32,
  parameter int LANES    = 4,
  parameter int NUM_BUFS = 2,
  localparam int BEATS   = 64 / LANES,
  localparam int BEAT_W  = (BEATS > 2) ? $clog2(BEATS) : 1,
  localparam int LVL_W   = $clog2(NUM_BUFS) + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    img_start_i,
  input  logic                    img_end_i,
  input  logic                    mode_transpose_i,
  input  logic                    inport_valid_i,
  input  logic [DATA_W-1:0]       inport_data_i,
  input  logic [5:0]              inport_idx_i,
  output logic                    inport_accept_o,
  output logic                    outport_valid_o,
  output logic [LANES*DATA_W-1:0] outport_data_o,
  output logic [BEAT_W-1:0]       outport_idx_o,
  output logic                    outport_last_o,
  input  logic                    outport_ready_i,
  output logic [LVL_W-1:0]        buf_level_o,
  output logic                    idle_o
);

  localparam int PTR_W  = $clog2(NUM_BUFS);
  localparam int GROUPS = 8 / LANES;

  logic [DATA_W-1:0]       mem_q [NUM_BUFS*64];
  logic [NUM_BUFS-1:0]     full_q, full_d, mode_q, mode_d;
  // wr_ptr: buffer being filled; rd_ptr: buffer whose beat sits in the output
  // register; ld_ptr/ld_beat: next beat to load (one block ahead of rd_ptr
  // while the last beat of rd_ptr is waiting for its handshake).
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, ld_ptr_q, ld_ptr_d;
  logic [BEAT_W-1:0]       ld_beat_q, ld_beat_d;
  logic                    dirty_q, dirty_d;
  logic [LVL_W-1:0]        level_q, level_d;
  logic                    acc_q, acc_d, idle_q, idle_d;
  logic                    out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [BEAT_W-1:0]       out_idx_q, out_idx_d;
  logic [LANES*DATA_W-1:0] out_data_q, out_data_d, beat_data_s;
  logic                    wr_en_s, complete_s, hs_s, free_s, load_s;

  // Raster position of one lane of a beat.
  function automatic logic [5:0] sample_idx(input logic tr, input logic [BEAT_W-1:0] beat,
                                            input int lane);
    int b, c, g;
    b = int'(beat);
    c = b / GROUPS;
    g = b % GROUPS;
    if (tr) begin
      sample_idx = 6'((g * LANES + lane) * 8 + c);
    end else begin
      sample_idx = 6'(b * LANES + lane);
    end
  endfunction

  // Gather the LANES samples of the next beat to load.
  always_comb begin
    beat_data_s = '0;
    for (int l = 0; l < LANES; l++) begin
      beat_data_s[l*DATA_W +: DATA_W] =
        mem_q[{ld_ptr_q, sample_idx(mode_q[ld_ptr_q], ld_beat_q, l)}];
    end
  end

  // Block storage; only accepted samples are written.
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      mem_q[{wr_ptr_q, inport_idx_i}] <= inport_data_i;
    end
  end

  // Next-state logic for write side, read engine and status.
  always_comb begin
    full_d      = full_q;
    mode_d      = mode_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ld_ptr_d    = ld_ptr_q;
    ld_beat_d   = ld_beat_q;
    dirty_d     = dirty_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_idx_d   = out_idx_q;
    out_data_d  = out_data_q;

    wr_en_s    = inport_valid_i && acc_q;
    // A discard in the same cycle as idx 63 swallows the completion too.
    complete_s = wr_en_s && (inport_idx_i == 6'd63) && !img_end_i;
    hs_s       = out_valid_q && outport_ready_i;
    free_s     = hs_s && out_last_q;
    load_s     = full_q[ld_ptr_q] && (!out_valid_q || outport_ready_i);

    if (wr_en_s) begin
      dirty_d = 1'b1;
    end else begin
      dirty_d = dirty_q;
    end
    if (complete_s) begin
      full_d[wr_ptr_q] = 1'b1;
      mode_d[wr_ptr_q] = mode_transpose_i;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      dirty_d          = 1'b0;
    end
    if (img_end_i) begin
      dirty_d = 1'b0;
    end
    if (free_s) begin
      full_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = rd_ptr_q + PTR_W'(1);
    end

    if (load_s) begin
      out_valid_d = 1'b1;
      out_data_d  = beat_data_s;
      out_idx_d   = ld_beat_q;
      out_last_d  = (ld_beat_q == BEAT_W'(BEATS - 1));
      ld_beat_d   = ld_beat_q + BEAT_W'(1);
      if (ld_beat_q == BEAT_W'(BEATS - 1)) begin
        ld_ptr_d = ld_ptr_q + PTR_W'(1);
      end else begin
        ld_ptr_d = ld_ptr_q;
      end
    end else if (hs_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    level_d = level_q + LVL_W'(complete_s) - LVL_W'(free_s);

    // Image start overrides everything, dropping any beat in flight.
    if (img_start_i) begin
      full_d      = '0;
      mode_d      = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      ld_ptr_d    = '0;
      ld_beat_d   = '0;
      dirty_d     = 1'b0;
      level_d     = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      out_idx_d   = '0;
      out_data_d  = '0;
    end

    acc_d  = !full_d[wr_ptr_d];
    idle_d = (level_d == '0) && !dirty_d && !out_valid_d;
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      full_q      <= '0;
      mode_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ld_ptr_q    <= '0;
      ld_beat_q   <= '0;
      dirty_q     <= 1'b0;
      level_q     <= '0;
      acc_q       <= 1'b1;
      idle_q      <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_idx_q   <= '0;
      out_data_q  <= '0;
    end else begin
      full_q      <= full_d;
      mode_q      <= mode_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ld_ptr_q    <= ld_ptr_d;
      ld_beat_q   <= ld_beat_d;
      dirty_q     <= dirty_d;
      level_q     <= level_d;
      acc_q       <= acc_d;
      idle_q      <= idle_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_idx_q   <= out_idx_d;
      out_data_q  <= out_data_d;
    end
  end

  assign inport_accept_o = acc_q;
  assign outport_valid_o = out_valid_q;
  assign outport_data_o  = out_data_q;
  assign outport_idx_o   = out_idx_q;
  assign outport_last_o  = out_last_q;
  assign buf_level_o     = level_q;
  assign idle_o          = idle_q;

endmodule
